// File: rtl/lcd_fill_rect.sv
// Fills an ST7735 window with one RGB565 colour: CASET, RASET, RAMWR, then hi/lo pixel bytes,
// one 9-bit word per en_write_fill, paced by the SPI writer's wr_done.
module lcd_fill_rect #(
  parameter logic [7:0] X_OFFSET = 8'd2,
  parameter logic [7:0] Y_OFFSET = 8'd3,
  parameter logic [7:0] MAX_XY   = 8'd127
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        fill_start,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [7:0]  y0,
  input  logic [7:0]  y1,
  input  logic [15:0] color,
  input  logic        wr_done,
  output logic [8:0]  fill_data,
  output logic        en_write_fill,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        fill_err
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t      state;
  logic [7:0]  x0_q, x1_q, y0_q, y1_q;
  logic [15:0] color_q;
  logic [3:0]  word_idx;   // 0..10 header words, 11 = pixel phase
  logic        lo_byte;
  logic [14:0] pix_cnt;

  logic        reject;
  logic [7:0]  dx, dy;
  logic [14:0] width, height;
  logic [8:0]  next_word;
  logic        last_word;

  always_comb begin
    reject = (x1_q < x0_q) || (y1_q < y0_q) ||
             (x0_q > MAX_XY) || (x1_q > MAX_XY) ||
             (y0_q > MAX_XY) || (y1_q > MAX_XY);
    dx     = x1_q - x0_q;
    dy     = y1_q - y0_q;
    width  = {7'd0, dx} + 15'd1;
    height = {7'd0, dy} + 15'd1;
    last_word = (word_idx == 4'd11) && lo_byte && (pix_cnt == 15'd1);

    // Word that follows the one currently on fill_data.
    next_word = {1'b1, color_q[15:8]};
    case (word_idx)
      4'd0:    next_word = {1'b1, 8'h00};
      4'd1:    next_word = {1'b1, x0_q + X_OFFSET};
      4'd2:    next_word = {1'b1, 8'h00};
      4'd3:    next_word = {1'b1, x1_q + X_OFFSET};
      4'd4:    next_word = {1'b0, 8'h2B};
      4'd5:    next_word = {1'b1, 8'h00};
      4'd6:    next_word = {1'b1, y0_q + Y_OFFSET};
      4'd7:    next_word = {1'b1, 8'h00};
      4'd8:    next_word = {1'b1, y1_q + Y_OFFSET};
      4'd9:    next_word = {1'b0, 8'h2C};
      4'd11:   next_word = lo_byte ? {1'b1, color_q[15:8]} : {1'b1, color_q[7:0]};
      default: next_word = {1'b1, color_q[15:8]};
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      x0_q          <= '0;
      x1_q          <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      color_q       <= '0;
      word_idx      <= '0;
      lo_byte       <= 1'b0;
      pix_cnt       <= '0;
      fill_data     <= '0;
      en_write_fill <= 1'b0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
      fill_err      <= 1'b0;
    end else begin
      en_write_fill <= 1'b0;
      fill_done     <= 1'b0;
      fill_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fill_start) begin
            x0_q      <= x0;
            x1_q      <= x1;
            y0_q      <= y0;
            y1_q      <= y1;
            color_q   <= color;
            fill_busy <= 1'b1;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (reject) begin
            fill_done <= 1'b1;
            fill_err  <= 1'b1;
            fill_busy <= 1'b0;
            state     <= S_FIN;
          end else begin
            pix_cnt       <= width * height;
            word_idx      <= '0;
            lo_byte       <= 1'b0;
            fill_data     <= {1'b0, 8'h2A};
            en_write_fill <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (wr_done) begin
            if (last_word) begin
              fill_done <= 1'b1;
              fill_busy <= 1'b0;
              state     <= S_FIN;
            end else begin
              fill_data     <= next_word;
              en_write_fill <= 1'b1;
              state         <= S_ISSUE;
              if (word_idx != 4'd11) begin
                word_idx <= word_idx + 4'd1;
              end else if (!lo_byte) begin
                lo_byte <= 1'b1;
              end else begin
                lo_byte <= 1'b0;
                pix_cnt <= pix_cnt - 15'd1;
              end
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Scoreboard bench for lcd_fill_rect: a rectangle model queues the expected word stream,
// a writer model acks words, and a monitor pops and compares every word and done pulse.
module tb_lcd_fill_rect;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        fill_start = 1'b0;
  logic [7:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [15:0] color = '0;
  logic        wr_done = 1'b0;
  logic [8:0]  fill_data;
  logic        en_write_fill, fill_busy, fill_done, fill_err;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned words_seen = 0;
  logic [8:0]  exp_q[$];
  bit          done_q[$];
  int unsigned ack_dly = 1;
  bit          rand_dly = 1'b0;
  bit          pause = 1'b0;
  bit          prev_en = 1'b0;
  int unsigned wr_d;

  always #5 sys_clk = ~sys_clk;

  lcd_fill_rect #(.X_OFFSET(8'd2), .Y_OFFSET(8'd3), .MAX_XY(8'd127)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fill_start(fill_start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .wr_done(wr_done),
    .fill_data(fill_data), .en_write_fill(en_write_fill), .fill_busy(fill_busy),
    .fill_done(fill_done), .fill_err(fill_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: what the panel must receive for a rectangle request.
  function automatic bit model(input logic [7:0] a0, a1, b0, b1, input logic [15:0] c);
    logic [7:0] cx0, cx1, ry0, ry1;
    if (a1 < a0 || b1 < b0 || a0 > 127 || a1 > 127 || b0 > 127 || b1 > 127) begin
      done_q.push_back(1'b1);
      return 1'b1;
    end
    cx0 = a0 + 8'd2; cx1 = a1 + 8'd2; ry0 = b0 + 8'd3; ry1 = b1 + 8'd3;
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, cx0});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, cx1});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, ry0});
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, ry1});
    exp_q.push_back({1'b0, 8'h2C});
    for (int r = 0; r <= int'(b1) - int'(b0); r++)
      for (int k = 0; k <= int'(a1) - int'(a0); k++) begin
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
    done_q.push_back(1'b0);
    return 1'b0;
  endfunction

  // Writer model: acks each word after a delay, holds off while paused.
  initial forever begin
    @(negedge sys_clk);
    if (sys_rst_n && en_write_fill) begin
      wr_d = rand_dly ? $urandom_range(1, 4) : ack_dly;
      repeat (wr_d) @(posedge sys_clk);
      while (pause) @(posedge sys_clk);
      #1 wr_done = 1'b1;
      @(posedge sys_clk);
      #1 wr_done = 1'b0;
    end
  end

  // Monitor: every presented word / done pulse is popped and compared.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (en_write_fill && prev_en) fail_now("en_write_fill_multi_cycle");
      if (en_write_fill) begin
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else begin
          check("word", {23'd0, fill_data}, {23'd0, exp_q.pop_front()});
          words_seen++;
        end
      end
      if (fill_done) begin
        if (done_q.size() == 0) fail_now("unexpected_fill_done");
        else check("fill_err", {31'd0, fill_err}, {31'd0, done_q.pop_front()});
      end
      prev_en = en_write_fill;
    end else prev_en = 1'b0;
  end

  task automatic run_fill(input logic [7:0] a0, a1, b0, b1, input logic [15:0] c,
                          input bit mid, input int unsigned budget);
    int unsigned k, first_en, base;
    bit busy_ok, got_done, pulse_nxt, rej;
    base = words_seen;
    rej = model(a0, a1, b0, b1, c);
    @(posedge sys_clk); #1;
    x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c; fill_start = 1'b1;
    k = 0; first_en = 0; busy_ok = 1'b1; got_done = 1'b0; pulse_nxt = 1'b0;
    while (!got_done && k < budget) begin
      @(posedge sys_clk); #1;
      fill_start = pulse_nxt;
      if (pulse_nxt) begin
        x0 = 8'($urandom); x1 = 8'($urandom); y0 = 8'($urandom); y1 = 8'($urandom);
        color = 16'($urandom);
      end
      pulse_nxt = 1'b0;
      k++;
      @(negedge sys_clk);
      if (en_write_fill && first_en == 0) first_en = k;
      if (fill_done) begin
        got_done = 1'b1;
        check("busy_low_at_done", {31'd0, fill_busy}, 32'd0);
      end else if (!fill_busy) busy_ok = 1'b0;
      if (mid && (k == 20 || (wr_done && exp_q.size() == 0))) pulse_nxt = 1'b1;
    end
    if (!got_done) begin
      fail_now("fill_done_timeout");
      exp_q.delete(); done_q.delete();
    end
    check("busy_throughout", {31'd0, busy_ok}, 32'd1);
    check("first_en_latency", first_en, rej ? 32'd0 : 32'd2);
    if (rej) check("reject_done_latency", k, 32'd2);
    else check("word_count", words_seen - base,
               11 + 2 * (int'(a1) - int'(a0) + 1) * (int'(b1) - int'(b0) + 1));
    @(posedge sys_clk); #1 fill_start = 1'b0;
    @(negedge sys_clk);
    check("done_single_pulse", {31'd0, fill_done}, 32'd0);
    check("idle_after_done", {31'd0, fill_busy}, 32'd0);
    if (mid) begin
      repeat (5) @(negedge sys_clk);
      check("late_start_ignored", {31'd0, fill_busy}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] a0, b0, a1, b1;
    logic [8:0] rec;
    int unsigned base, k;
    bit stable_ok;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_fill_data", {23'd0, fill_data}, 32'd0);
    check("rst_en", {31'd0, en_write_fill}, 32'd0);
    check("rst_busy", {31'd0, fill_busy}, 32'd0);
    check("rst_done", {31'd0, fill_done}, 32'd0);
    check("rst_err", {31'd0, fill_err}, 32'd0);
    #2 sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // Single pixel, writer acks 3 cycles after each word
    rand_dly = 1'b0; ack_dly = 3;
    run_fill(8'd0, 8'd0, 8'd0, 8'd0, 16'hF800, 1'b0, 500);

    // Random small rectangles, random ack delay
    rand_dly = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a0 = 8'($urandom_range(0, 127)); b0 = 8'($urandom_range(0, 127));
      a1 = (a0 > 8'd123) ? 8'd127 : a0 + 8'($urandom_range(0, 4));
      b1 = (b0 > 8'd124) ? 8'd127 : b0 + 8'($urandom_range(0, 3));
      run_fill(a0, a1, b0, b1, 16'($urandom), 1'b0, 2000);
    end
    run_fill(8'd125, 8'd127, 8'd127, 8'd127, 16'hA5C3, 1'b0, 2000);

    // Rejected requests
    run_fill(8'd10, 8'd5, 8'd0, 8'd0, 16'h1234, 1'b0, 50);
    run_fill(8'd0, 8'd0, 8'd0, 8'd200, 16'h1234, 1'b0, 50);
    run_fill(8'd0, 8'd128, 8'd0, 8'd0, 16'h1234, 1'b0, 50);
    run_fill(8'd0, 8'd0, 8'd9, 8'd8, 16'h1234, 1'b0, 50);

    // Starts during a fill (mid-header and on the fill_done cycle) are ignored
    run_fill(8'd3, 8'd6, 8'd4, 8'd5, 16'h7E0F, 1'b1, 2000);

    // Writer stalls: word must hold, no repeat enable, no advance
    base = words_seen; pause = 1'b1;
    void'(model(8'd0, 8'd1, 8'd0, 8'd0, 16'hBEEF));
    @(posedge sys_clk); #1;
    x0 = 8'd0; x1 = 8'd1; y0 = 8'd0; y1 = 8'd0; color = 16'hBEEF; fill_start = 1'b1;
    @(posedge sys_clk); #1 fill_start = 1'b0;
    k = 0;
    do begin @(negedge sys_clk); k++; end while (!en_write_fill && k < 20);
    if (!en_write_fill) fail_now("stall_first_en_timeout");
    rec = fill_data; stable_ok = 1'b1;
    repeat (50) begin
      @(negedge sys_clk);
      if (en_write_fill || fill_data !== rec || fill_done) stable_ok = 1'b0;
    end
    check("stall_hold_stable", {31'd0, stable_ok}, 32'd1);
    check("stall_no_advance", words_seen - base, 32'd1);
    pause = 1'b0;
    k = 0;
    do begin @(negedge sys_clk); k++; end while (!fill_done && k < 500);
    if (!fill_done) begin fail_now("stall_done_timeout"); exp_q.delete(); done_q.delete(); end
    check("stall_word_count", words_seen - base, 32'd15);

    // Full screen, fastest writer
    rand_dly = 1'b0; ack_dly = 1;
    run_fill(8'd0, 8'd127, 8'd0, 8'd127, 16'h001F, 1'b0, 70000);

    // Reset during pixel phase abandons the fill
    rand_dly = 1'b1; base = words_seen;
    void'(model(8'd0, 8'd19, 8'd0, 8'd19, 16'h5555));
    @(posedge sys_clk); #1;
    x0 = 8'd0; x1 = 8'd19; y0 = 8'd0; y1 = 8'd19; color = 16'h5555; fill_start = 1'b1;
    @(posedge sys_clk); #1 fill_start = 1'b0;
    k = 0;
    while (words_seen - base < 20 && k < 2000) begin @(negedge sys_clk); k++; end
    check("pre_reset_progress", {31'd0, words_seen - base >= 20}, 32'd1);
    @(negedge sys_clk); #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, fill_busy}, 32'd0);
    check("async_rst_data", {23'd0, fill_data}, 32'd0);
    check("async_rst_en", {31'd0, en_write_fill}, 32'd0);
    check("async_rst_done", {30'd0, fill_done, fill_err}, 32'd0);
    exp_q.delete(); done_q.delete();
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);
    run_fill(8'd5, 8'd5, 8'd6, 8'd6, 16'h0F0F, 1'b0, 2000);

    repeat (5) @(negedge sys_clk);
    check("words_left", exp_q.size(), 32'd0);
    check("dones_left", done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
